// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-port-style AXI4 memory responder backed by a
// DEPTH x 64-bit word array. Independent write and read FSMs, one burst each.
// Optional feature macro: AXI_MEM_RESP_ERR_EN (address-range checking with
// SLVERR responses). Without it, addresses alias modulo DEPTH words.
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for AW handshake (awready=1)
//   W_DATA | accepting W beats until beat awlen (wready=1)
//   W_RESP | presenting B response (bvalid=1)
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for AR handshake (arready=1)
//   R_DATA | presenting R beats until the rlast handshake (rvalid=1)
module axi_mem_responder #(
   parameter int ID_W  = 4,
   parameter int DEPTH = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            awvalid,
   input  logic [ID_W-1:0] awid,
   input  logic [31:0]     awaddr,
   input  logic [7:0]      awlen,
   input  logic [2:0]      awsize,
   input  logic [1:0]      awburst,
   output logic            awready,
   input  logic            wvalid,
   input  logic [63:0]     wdata,
   input  logic [7:0]      wstrb,
   input  logic            wlast,
   output logic            wready,
   output logic            bvalid,
   output logic [ID_W-1:0] bid,
   output logic [1:0]      bresp,
   input  logic            bready,
   input  logic            arvalid,
   input  logic [ID_W-1:0] arid,
   input  logic [31:0]     araddr,
   input  logic [7:0]      arlen,
   input  logic [2:0]      arsize,
   input  logic [1:0]      arburst,
   output logic            arready,
   output logic            rvalid,
   output logic [ID_W-1:0] rid,
   output logic [63:0]     rdata,
   output logic [1:0]      rresp,
   output logic            rlast,
   input  logic            rready
);

   localparam int AW = $clog2(DEPTH);

`ifdef AXI_MEM_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam logic [1:0] BURST_FIXED = 2'b00;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   // FIXED holds the address; INCR and WRAP both step by the transfer size.
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                             input logic [1:0] b);
      if (b == BURST_FIXED) return a;
      return a + (32'd1 << sz);
   endfunction

   function automatic logic out_of_range(input logic [31:0] a);
      return ERR_EN && (a[31:3] >= 29'(DEPTH));
   endfunction

   logic [63:0] mem [DEPTH];

   // Handshake readiness is held off until the first edge after reset release.
   logic rdy_en_q;

   logic [1:0]      w_state_q, w_state_d;
   logic [31:0]     w_addr_q, w_addr_d;
   logic [7:0]      w_len_q, w_len_d;
   logic [7:0]      w_cnt_q, w_cnt_d;
   logic [2:0]      w_size_q, w_size_d;
   logic [1:0]      w_burst_q, w_burst_d;
   logic [ID_W-1:0] w_id_q, w_id_d;
   logic            w_err_q, w_err_d;
   logic            w_oob;
   logic            mem_we;
   logic [AW-1:0]   w_idx;

   logic [0:0]      r_state_q, r_state_d;
   logic [31:0]     r_addr_q, r_addr_d;
   logic [7:0]      r_len_q, r_len_d;
   logic [7:0]      r_cnt_q, r_cnt_d;
   logic [2:0]      r_size_q, r_size_d;
   logic [1:0]      r_burst_q, r_burst_d;
   logic [ID_W-1:0] r_id_q, r_id_d;
   logic [63:0]     rdata_q, rdata_d;
   logic [1:0]      rresp_q, rresp_d;
   logic [31:0]     r_nxt_addr, r_load_addr;
   logic            r_load_oob;
   logic [63:0]     r_load_word;

   logic unused_wlast;
   assign unused_wlast = wlast;

   assign awready = (w_state_q == W_IDLE) && rdy_en_q;
   assign wready  = (w_state_q == W_DATA);
   assign bvalid  = (w_state_q == W_RESP);
   assign bid     = w_id_q;
   assign bresp   = {w_err_q && (w_state_q == W_RESP), 1'b0};

   assign arready = (r_state_q == R_IDLE) && rdy_en_q;
   assign rvalid  = (r_state_q == R_DATA);
   assign rlast   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
   assign rid     = r_id_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

   assign w_oob  = out_of_range(w_addr_q);
   assign w_idx  = w_addr_q[3 +: AW];
   assign mem_we = (w_state_q == W_DATA) && wvalid && !w_oob;

   // Write FSM next state and burst bookkeeping.
   always_comb begin
      w_state_d = w_state_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_size_d  = w_size_q;
      w_burst_d = w_burst_q;
      w_id_d    = w_id_q;
      w_err_d   = w_err_q;
      case (w_state_q)
         W_IDLE: begin
            if (awvalid && rdy_en_q) begin
               w_state_d = W_DATA;
               w_id_d    = awid;
               w_addr_d  = awaddr;
               w_len_d   = awlen;
               w_size_d  = awsize;
               w_burst_d = awburst;
               w_cnt_d   = 8'd0;
               w_err_d   = 1'b0;
            end
         end
         W_DATA: begin
            if (wvalid) begin
               w_err_d = w_err_q | w_oob;
               if (w_cnt_q == w_len_q) begin
                  w_state_d = W_RESP;
               end else begin
                  w_cnt_d  = w_cnt_q + 8'd1;
                  w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
               end
            end
         end
         W_RESP: begin
            if (bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read FSM next state; rdata is loaded from the array before any same-cycle write lands.
   always_comb begin
      r_nxt_addr  = next_addr(r_addr_q, r_size_q, r_burst_q);
      r_load_addr = (r_state_q == R_IDLE) ? araddr : r_nxt_addr;
      r_load_oob  = out_of_range(r_load_addr);
      r_load_word = r_load_oob ? 64'd0 : mem[r_load_addr[3 +: AW]];
      r_state_d   = r_state_q;
      r_addr_d    = r_addr_q;
      r_len_d     = r_len_q;
      r_cnt_d     = r_cnt_q;
      r_size_d    = r_size_q;
      r_burst_d   = r_burst_q;
      r_id_d      = r_id_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (arvalid && rdy_en_q) begin
               r_state_d = R_DATA;
               r_id_d    = arid;
               r_addr_d  = araddr;
               r_len_d   = arlen;
               r_size_d  = arsize;
               r_burst_d = arburst;
               r_cnt_d   = 8'd0;
               rdata_d   = r_load_word;
               rresp_d   = {r_load_oob, 1'b0};
            end
         end
         R_DATA: begin
            if (rready) begin
               if (r_cnt_q == r_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_cnt_d  = r_cnt_q + 8'd1;
                  r_addr_d = r_nxt_addr;
                  rdata_d  = r_load_word;
                  rresp_d  = {r_load_oob, 1'b0};
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Control and response registers; the memory array itself is never reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_en_q  <= 1'b0;
         w_state_q <= W_IDLE;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_size_q  <= '0;
         w_burst_q <= '0;
         w_id_q    <= '0;
         w_err_q   <= 1'b0;
         r_state_q <= R_IDLE;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_size_q  <= '0;
         r_burst_q <= '0;
         r_id_q    <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         rdy_en_q  <= 1'b1;
         w_state_q <= w_state_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_id_q    <= w_id_d;
         w_err_q   <= w_err_d;
         r_state_q <= r_state_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_id_q    <= r_id_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Byte-lane writes into the word array.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 8; i++) begin
            if (wstrb[i]) mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Testbench for axi_mem_responder: table of single-beat vectors plus
// hand-written burst, stall, collision and mid-burst reset sequences.
module tb_axi_mem_responder;

   localparam int ID_W  = 4;
   localparam int DEPTH = 1024;
`ifdef AXI_MEM_RESP_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif
   localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

   logic clk, rst;
   logic awvalid, awready, wvalid, wlast, wready, bvalid, bready;
   logic arvalid, arready, rvalid, rready, rlast;
   logic [ID_W-1:0] awid, bid, arid, rid;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [63:0] wdata, rdata;

   axi_mem_responder #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
      .bvalid(bvalid), .bid(bid), .bresp(bresp), .bready(bready),
      .arvalid(arvalid), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arready(arready),
      .rvalid(rvalid), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h, required %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [ID_W-1:0] id;
      logic [63:0]     data;
      logic [1:0]      resp;
      logic            last;
   } rexp_t;
   typedef struct {
      logic [ID_W-1:0] id;
      logic [1:0]      resp;
   } bexp_t;
   rexp_t exp_r[$];
   bexp_t exp_b[$];

   logic [63:0] model_mem [DEPTH];

   function automatic bit m_oob(input logic [31:0] a);
      return ERR && (a >= 32'(DEPTH * 8));
   endfunction
   function automatic int m_idx(input logic [31:0] a);
      return int'(a[31:3]) % DEPTH;
   endfunction

   // Scoreboard monitor: pops on handshakes, checks hold-stable during stalls.
   bit stall_r = 0, stall_b = 0;
   rexp_t s_r;
   bexp_t s_b;
   always @(negedge clk) begin
      if (rst) begin
         stall_r = 0;
         stall_b = 0;
      end else begin
         if (stall_r) begin
            chk("r_hold_valid", rvalid, 1);
            chk("r_hold_data", rdata, s_r.data);
            chk("r_hold_id", rid, s_r.id);
            chk("r_hold_resp", rresp, s_r.resp);
            chk("r_hold_last", rlast, s_r.last);
         end
         if (stall_b) begin
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_id", bid, s_b.id);
            chk("b_hold_resp", bresp, s_b.resp);
         end
         if (rvalid && rready) begin
            if (exp_r.size() == 0) chk("r_unexpected_beat", rvalid, 0);
            else begin
               rexp_t e;
               e = exp_r.pop_front();
               chk("r_id", rid, e.id);
               chk("r_data", rdata, e.data);
               chk("r_resp", rresp, e.resp);
               chk("r_last", rlast, e.last);
            end
         end
         if (bvalid && bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", bvalid, 0);
            else begin
               bexp_t e;
               e = exp_b.pop_front();
               chk("b_id", bid, e.id);
               chk("b_resp", bresp, e.resp);
            end
         end
         stall_r = rvalid && !rready;
         s_r = '{rid, rdata, rresp, rlast};
         stall_b = bvalid && !bready;
         s_b = '{bid, bresp};
      end
   end

   task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [63:0] d0, input logic [63:0] dstep,
                           input logic [7:0] strb, input int bstall, input bit use_exp,
                           input logic [1:0] exp_resp);
      logic [31:0] a;
      logic [63:0] d;
      bit anyoob;
      bexp_t e;
      int t;
      a = addr;
      anyoob = 0;
      for (int i = 0; i <= int'(len); i++) begin
         d = d0 + dstep * 64'(i);
         if (m_oob(a)) anyoob = 1;
         else for (int b = 0; b < 8; b++) if (strb[b]) model_mem[m_idx(a)][b*8 +: 8] = d[b*8 +: 8];
         if (burst != FIXED) a = a + 32'd8;
      end
      e.id = id;
      e.resp = use_exp ? exp_resp : (anyoob ? 2'b10 : 2'b00);
      exp_b.push_back(e);
      if (bstall > 0) bready = 0;
      awvalid = 1; awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst;
      t = 0;
      while (!awready && t < 50) begin @(negedge clk); t++; end
      chk("aw_ready_wait", awready, 1);
      @(posedge clk); #1;
      awvalid = 0;
      for (int i = 0; i <= int'(len); i++) begin
         wvalid = 1; wdata = d0 + dstep * 64'(i); wstrb = strb; wlast = (i == int'(len));
         t = 0;
         while (!wready && t < 50) begin @(negedge clk); t++; end
         chk("w_ready_wait", wready, 1);
         @(posedge clk); #1;
      end
      wvalid = 0; wlast = 0;
      if (bstall > 0) begin
         repeat (bstall) @(posedge clk);
         #1;
         bready = 1;
      end
      t = 0;
      while (exp_b.size() != 0 && t < 50) begin @(negedge clk); t++; end
      chk("b_done", 64'(exp_b.size()), 0);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_beat, input int stall_n,
                          input bit use_exp, input logic [63:0] exp_data, input logic [1:0] exp_resp);
      logic [31:0] a;
      rexp_t e;
      int t;
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
         e.id = id;
         e.last = (i == int'(len));
         if (use_exp) begin e.data = exp_data; e.resp = exp_resp; end
         else if (m_oob(a)) begin e.data = 64'd0; e.resp = 2'b10; end
         else begin e.data = model_mem[m_idx(a)]; e.resp = 2'b00; end
         exp_r.push_back(e);
         if (burst != FIXED) a = a + 32'd8;
      end
      arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst;
      t = 0;
      while (!arready && t < 50) begin @(negedge clk); t++; end
      chk("ar_ready_wait", arready, 1);
      chk("r_before_ar", rvalid, 0);
      @(posedge clk); #1;
      arvalid = 0;
      chk("r_latency", rvalid, 1);
      for (int i = 0; i <= int'(len); i++) begin
         if (i > 0) chk("r_no_bubble", rvalid, 1);
         if (i == stall_beat) begin
            rready = 0;
            repeat (stall_n) @(posedge clk);
            #1;
            rready = 1;
         end
         t = 0;
         while (!rvalid && t < 50) begin @(negedge clk); t++; end
         @(posedge clk); #1;
      end
      chk("r_done", 64'(exp_r.size()), 0);
      chk("r_idle_arready", arready, 1);
   endtask

   typedef struct {
      bit              wr;
      logic [ID_W-1:0] id;
      logic [31:0]     addr;
      logic [63:0]     data;
      logic [7:0]      strb;
      logic [63:0]     exp_data;
      logic [1:0]      exp_resp;
   } vec_t;
   vec_t tbl [9];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, required finish before 300us");
      $fatal(1);
   end

   initial begin
      rexp_t e;
      bexp_t eb;
      int t;
      tbl[0] = '{1'b1, 4'd3, 32'h10,   64'h1122334455667788, 8'hFF, 64'h0, 2'b00};
      tbl[1] = '{1'b0, 4'd5, 32'h10,   64'h0, 8'h00, 64'h1122334455667788, 2'b00};
      tbl[2] = '{1'b1, 4'd1, 32'h20,   64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 2'b00};
      tbl[3] = '{1'b1, 4'd2, 32'h20,   64'h0, 8'h0F, 64'h0, 2'b00};
      tbl[4] = '{1'b0, 4'd6, 32'h20,   64'h0, 8'h00, 64'hFFFFFFFF00000000, 2'b00};
      tbl[5] = '{1'b1, 4'd7, 32'h0,    64'hA5A5A5A55A5A5A5A, 8'hFF, 64'h0, 2'b00};
      tbl[6] = '{1'b1, 4'd4, 32'h2000, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0, ERR ? 2'b10 : 2'b00};
      tbl[7] = '{1'b0, 4'd9, 32'h0,    64'h0, 8'h00,
                 ERR ? 64'hA5A5A5A55A5A5A5A : 64'hDEADBEEFCAFEF00D, 2'b00};
      tbl[8] = '{1'b0, 4'd8, 32'h2000, 64'h0, 8'h00,
                 ERR ? 64'h0 : 64'hDEADBEEFCAFEF00D, ERR ? 2'b10 : 2'b00};

      rst = 1; awvalid = 1; arvalid = 1; wvalid = 0; wlast = 0; bready = 1; rready = 1;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
      repeat (2) @(negedge clk);
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_arready", arready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rlast", rlast, 0);
      chk("rst_bid", bid, 0);
      chk("rst_rid", rid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_rdata", rdata, 0);
      awvalid = 0; arvalid = 0;
      rst = 0;
      #1;
      chk("awready_before_edge", awready, 0);
      @(posedge clk); #1;
      chk("awready_first_edge", awready, 1);
      chk("arready_first_edge", arready, 1);

      for (int i = 0; i < 9; i++) begin
         if (tbl[i].wr)
            do_write(tbl[i].id, tbl[i].addr, 8'd0, INCR, tbl[i].data, 64'd0, tbl[i].strb, 0, 1'b1,
                     tbl[i].exp_resp);
         else
            do_read(tbl[i].id, tbl[i].addr, 8'd0, INCR, -1, 0, 1'b1, tbl[i].exp_data, tbl[i].exp_resp);
      end

      // INCR burst with a two-cycle R stall on beat 1, B stall on a single write.
      do_write(4'd1, 32'h100, 8'd3, INCR, 64'd1, 64'd1, 8'hFF, 0, 1'b0, 2'b00);
      do_read(4'd2, 32'h100, 8'd3, INCR, 1, 2, 1'b0, 64'd0, 2'b00);
      do_write(4'd3, 32'h180, 8'd0, INCR, 64'h5555AAAA5555AAAA, 64'd0, 8'hFF, 2, 1'b0, 2'b00);
      // FIXED holds the address; WRAP steps like INCR; 32-bit address wrap.
      do_write(4'd4, 32'h300, 8'd2, FIXED, 64'd10, 64'd1, 8'hFF, 0, 1'b0, 2'b00);
      do_read(4'd5, 32'h300, 8'd1, FIXED, -1, 0, 1'b0, 64'd0, 2'b00);
      do_write(4'd6, 32'h308, 8'd1, WRAP, 64'h21, 64'd1, 8'hFF, 0, 1'b0, 2'b00);
      do_read(4'd7, 32'h308, 8'd1, INCR, -1, 0, 1'b0, 64'd0, 2'b00);
      do_write(4'd8, 32'hFFFFFFF8, 8'd1, INCR, 64'h77, 64'd1, 8'hFF, 0, 1'b0, 2'b00);
      do_read(4'd9, 32'hFFFFFFF8, 8'd1, INCR, -1, 0, 1'b0, 64'd0, 2'b00);

      // Same-cycle W write and AR load on one word: R carries the old data.
      do_write(4'd1, 32'h400, 8'd0, INCR, 64'h0123456789ABCDEF, 64'd0, 8'hFF, 0, 1'b0, 2'b00);
      e = '{4'd2, 64'h0123456789ABCDEF, 2'b00, 1'b1};
      exp_r.push_back(e);
      eb = '{4'd3, 2'b00};
      exp_b.push_back(eb);
      awvalid = 1; awid = 4'd3; awaddr = 32'h400; awlen = 0; awsize = 3'd3; awburst = INCR;
      @(posedge clk); #1;
      awvalid = 0;
      wvalid = 1; wdata = 64'hFEDCBA9876543210; wstrb = 8'hFF; wlast = 1;
      arvalid = 1; arid = 4'd2; araddr = 32'h400; arlen = 0; arsize = 3'd3; arburst = INCR;
      chk("coll_wready", wready, 1);
      chk("coll_arready", arready, 1);
      @(posedge clk); #1;
      wvalid = 0; wlast = 0; arvalid = 0;
      t = 0;
      while ((exp_r.size() != 0 || exp_b.size() != 0) && t < 50) begin @(negedge clk); t++; end
      chk("coll_done", 64'(exp_r.size() + exp_b.size()), 0);
      @(posedge clk); #1;
      model_mem[m_idx(32'h400)] = 64'hFEDCBA9876543210;
      do_read(4'd4, 32'h400, 8'd0, INCR, -1, 0, 1'b1, 64'hFEDCBA9876543210, 2'b00);

      // Reset in the middle of a len-7 read (during beat 2), then a fresh burst.
      do_write(4'd5, 32'h200, 8'd7, INCR, 64'h1000, 64'h11, 8'hFF, 0, 1'b0, 2'b00);
      for (int i = 0; i < 8; i++) begin
         e = '{4'd6, model_mem[m_idx(32'h200 + 32'(i * 8))], 2'b00, i == 7};
         exp_r.push_back(e);
      end
      arvalid = 1; arid = 4'd6; araddr = 32'h200; arlen = 8'd7; arsize = 3'd3; arburst = INCR;
      @(posedge clk); #1;
      arvalid = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midrst_beat2_valid", rvalid, 1);
      chk("midrst_popped", 64'(exp_r.size()), 6);
      rst = 1;
      #1;
      chk("midrst_rvalid", rvalid, 0);
      chk("midrst_rlast", rlast, 0);
      chk("midrst_arready", arready, 0);
      chk("midrst_rdata", rdata, 0);
      exp_r.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      #1;
      chk("postrst_arready_low", arready, 0);
      @(posedge clk); #1;
      chk("postrst_arready", arready, 1);
      do_read(4'd7, 32'h100, 8'd3, INCR, -1, 0, 1'b0, 64'd0, 2'b00);
      do_read(4'd8, 32'h200, 8'd7, INCR, 3, 1, 1'b0, 64'd0, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
